// File: rtl/cpe_frame_ctrl.sv
// cpe_frame_ctrl: frames the symbol stream into the CPE estimator,
// flushes it with zeros and gates its results to FRAME_LEN per frame.
//   clk, rst_n       : clock, async active-low reset
//   start, abort     : frame start pulse, synchronous abort
//   s_valid/s_ready  : upstream sample handshake, s_* sample words
//   cpe_en, cpe_*    : registered CPE pipeline enable and inputs
//   cpe_valid        : CPE result valid
//   m_valid, m_last  : gated result valid, last result of frame
//   busy, done       : not idle, normal completion pulse
//   err_timeout      : sticky drain overrun flag
module cpe_frame_ctrl #(
  parameter int WL        = 18,
  parameter int FRAME_LEN = 16200,
  parameter int CPE_LAT   = 8,
  parameter int CNT_W     = 14
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic signed [WL-1:0] s_re_h,
  input  logic signed [WL-1:0] s_im_h,
  input  logic signed [WL-1:0] s_re_u,
  input  logic signed [WL-1:0] s_im_u,
  output logic                 cpe_en,
  output logic signed [WL-1:0] cpe_re_hi,
  output logic signed [WL-1:0] cpe_im_hi,
  output logic signed [WL-1:0] cpe_re_ui,
  output logic signed [WL-1:0] cpe_im_ui,
  input  logic                 cpe_valid,
  output logic                 m_valid,
  output logic                 m_last,
  output logic                 busy,
  output logic                 done,
  output logic                 err_timeout
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] LEN =
    CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] LEN_M1 =
    CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] DRN_MAX =
    CNT_W'(CPE_LAT + 4);
  localparam logic [CNT_W-1:0] DRN_LAST =
    CNT_W'(CPE_LAT + 3);
  localparam logic [CNT_W-1:0] ONE =
    CNT_W'(1);

  state_t state, state_n;

  logic [CNT_W-1:0] in_cnt;
  logic [CNT_W-1:0] out_cnt;
  logic [CNT_W-1:0] drain_cnt;

  logic accept;
  logic go;
  logic out_full;
  logic drain_exp;
  logic timeout;

  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign s_ready = (state == RUN) &&
                   (in_cnt < LEN);
  assign accept  = s_valid & s_ready;
  assign go      = (state == IDLE) &
                   start & ~abort;

  assign m_valid = cpe_valid & busy &
                   (out_cnt < LEN);
  assign m_last  = m_valid &
                   (out_cnt == LEN_M1);

  // Completing on m_last lets done follow
  // the final result by exactly one cycle.
  assign out_full  = (out_cnt == LEN) |
                     m_last;
  assign drain_exp = (drain_cnt == DRN_LAST);
  assign timeout   = (state == DRAIN) &
                     drain_exp & ~out_full &
                     ~abort;

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (start) state_n = RUN;
      RUN: begin
        if (accept && in_cnt == LEN_M1)
          state_n = DRAIN;
      end
      DRAIN: begin
        if (out_full || drain_exp)
          state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (abort) state_n = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_cnt    <= '0;
      out_cnt   <= '0;
      drain_cnt <= '0;
    end else if (abort || go) begin
      in_cnt    <= '0;
      out_cnt   <= '0;
      drain_cnt <= '0;
    end else begin
      if (accept)
        in_cnt <= in_cnt + ONE;
      if (m_valid)
        out_cnt <= out_cnt + ONE;
      if (state == DRAIN &&
          drain_cnt < DRN_MAX)
        drain_cnt <= drain_cnt + ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       err_timeout <= 1'b0;
    else if (go)      err_timeout <= 1'b0;
    else if (timeout) err_timeout <= 1'b1;
  end

  // Idle enable cycles keep the sample
  // words so the CPE sees stable inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpe_en    <= 1'b0;
      cpe_re_hi <= '0;
      cpe_im_hi <= '0;
      cpe_re_ui <= '0;
      cpe_im_ui <= '0;
    end else if (abort) begin
      cpe_en <= 1'b0;
    end else if (accept) begin
      cpe_en    <= 1'b1;
      cpe_re_hi <= s_re_h;
      cpe_im_hi <= s_im_h;
      cpe_re_ui <= s_re_u;
      cpe_im_ui <= s_im_u;
    end else if (state == DRAIN) begin
      cpe_en    <= (state_n == DRAIN);
      cpe_re_hi <= '0;
      cpe_im_hi <= '0;
      cpe_re_ui <= '0;
      cpe_im_ui <= '0;
    end else begin
      cpe_en <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cpe_frame_ctrl.sv
// tb_cpe_frame_ctrl: randomized and directed frames
// against a queue-based frame model and a CPE delay model.
module tb_cpe_frame_ctrl;
  localparam int WL     = 18;
  localparam int FL     = 16;
  localparam int LAT    = 4;
  localparam int CW     = 5;
  localparam int DW     = 4 * WL;
  localparam int BUDGET = 200;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic s_valid = 1'b0;
  logic [WL-1:0] s_re_h = '0;
  logic [WL-1:0] s_im_h = '0;
  logic [WL-1:0] s_re_u = '0;
  logic [WL-1:0] s_im_u = '0;
  logic s_ready, cpe_en, cpe_valid;
  logic m_valid, m_last, busy, done;
  logic err_timeout;
  logic [WL-1:0] cpe_re_hi, cpe_im_hi;
  logic [WL-1:0] cpe_re_ui, cpe_im_ui;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpe_frame_ctrl #(
    .WL(WL), .FRAME_LEN(FL),
    .CPE_LAT(LAT), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .start(start), .abort(abort),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_re_h(s_re_h), .s_im_h(s_im_h),
    .s_re_u(s_re_u), .s_im_u(s_im_u),
    .cpe_en(cpe_en),
    .cpe_re_hi(cpe_re_hi), .cpe_im_hi(cpe_im_hi),
    .cpe_re_ui(cpe_re_ui), .cpe_im_ui(cpe_im_ui),
    .cpe_valid(cpe_valid),
    .m_valid(m_valid), .m_last(m_last),
    .busy(busy), .done(done),
    .err_timeout(err_timeout)
  );

  // CPE model: enable-gated 4-deep delay line,
  // emptied at frame end, abort or reset.
  logic tie0 = 1'b0;
  logic [DW-1:0] pd0, pd1, pd2, cd;
  logic pv0, pv1, pv2, cv;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv0 <= 0; pv1 <= 0; pv2 <= 0; cv <= 0;
      pd0 <= '0; pd1 <= '0; pd2 <= '0; cd <= '0;
    end else if (done || abort) begin
      pv0 <= 0; pv1 <= 0; pv2 <= 0; cv <= 0;
    end else if (cpe_en) begin
      pd0 <= {cpe_re_hi, cpe_im_hi,
              cpe_re_ui, cpe_im_ui};
      pv0 <= 1'b1;
      pd1 <= pd0; pv1 <= pv0;
      pd2 <= pd1; pv2 <= pv1;
      cd  <= pd2; cv  <= pv2;
    end else begin
      cv <= 1'b0;
    end
  end
  assign cpe_valid = cv & ~tie0;

  // Frame log, restarted by every real start.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] acc_q[$];
  logic [DW-1:0] res_q[$];
  int done_cnt = 0, done_cyc = 0;
  int last_mv = 0, mlast_cnt = 0;
  int mlast_bad = 0, en_cnt = 0;
  int en_mis = 0, drain_cyc = 0;
  bit acc_prev = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (start && !busy && !abort) begin
        acc_q.delete(); res_q.delete();
        done_cnt = 0; mlast_cnt = 0;
        mlast_bad = 0; en_cnt = 0;
        en_mis = 0; drain_cyc = 0;
      end
      if (busy && s_ready &&
          (cpe_en !== acc_prev))
        en_mis++;
      acc_prev = s_valid && s_ready;
      if (acc_prev)
        acc_q.push_back({s_re_h, s_im_h,
                         s_re_u, s_im_u});
      if (m_valid) begin
        res_q.push_back(cd);
        last_mv = cyc;
        if (m_last) begin
          mlast_cnt++;
          if (res_q.size() != FL) mlast_bad++;
        end
      end else if (m_last) begin
        mlast_bad++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (cpe_en) en_cnt++;
      if (busy && !s_ready && !done)
        drain_cyc++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_words(input bit rnd,
                           input int v);
    if (rnd) begin
      s_re_h = WL'($urandom);
      s_im_h = WL'($urandom);
      s_re_u = WL'($urandom);
      s_im_u = WL'($urandom);
    end else begin
      s_re_h = WL'(v);
      s_im_h = WL'(v);
      s_re_u = WL'(v);
      s_im_u = WL'(v);
    end
  endtask

  function automatic logic [DW-1:0] pat(int v);
    logic [WL-1:0] w;
    w = WL'(v);
    return {w, w, w, w};
  endfunction

  // vmode 0: continuous, 1: alternate, 2: random
  task automatic run_frame(input int vmode,
                           input bit rnd,
                           input bit poke,
                           output bit ok);
    int idx = 0;
    int n = 0;
    bit v;
    start = 1'b1;
    step();
    start = 1'b0;
    while (done_cnt == 0 && n < BUDGET) begin
      case (vmode)
        0:       v = 1'b1;
        1:       v = (n % 2 == 0);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      s_valid = v;
      set_words(rnd, idx + 1);
      start = poke && (n == 5);
      if (v && s_ready) idx++;
      step();
      n++;
    end
    s_valid = 1'b0;
    start = 1'b0;
    ok = (done_cnt != 0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_busy: got %b want 0", busy);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (s_ready !== 1'b0 || cpe_en !== 1'b0) begin
      errors++;
      $display("FAIL rst_hs: got ready=%b en=%b want 0 0",
               s_ready, cpe_en);
    end
    checks++;
    if (err_timeout !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL rst_flags: got err=%b done=%b want 0 0",
               err_timeout, done);
    end
    checks++;
    if ({cpe_re_hi, cpe_im_hi, cpe_re_ui,
         cpe_im_ui} !== '0) begin
      errors++;
      $display("FAIL rst_data: got %h want 0", cpe_re_hi);
    end
    checks++;
    if (m_valid !== 1'b0 || m_last !== 1'b0) begin
      errors++;
      $display("FAIL rst_m: got %b%b want 00",
               m_valid, m_last);
    end
  endtask

  task automatic test_continuous();
    bit ok;
    run_frame(0, 0, 0, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL cont_done: got none want pulse");
    end
    checks++;
    if (acc_q.size() != FL || res_q.size() != FL) begin
      errors++;
      $display("FAIL cont_count: got acc=%0d res=%0d want %0d",
               acc_q.size(), res_q.size(), FL);
    end
    for (int i = 0; i < int'(res_q.size()); i++) begin
      checks++;
      if (res_q[i] !== pat(i + 1)) begin
        errors++;
        $display("FAIL cont_res%0d: got %h want %h",
                 i, res_q[i], pat(i + 1));
      end
    end
    checks++;
    if (mlast_cnt != 1 || mlast_bad != 0) begin
      errors++;
      $display("FAIL cont_last: got cnt=%0d bad=%0d want 1 0",
               mlast_cnt, mlast_bad);
    end
    checks++;
    if (done_cnt != 1 || done_cyc != last_mv + 1) begin
      errors++;
      $display("FAIL cont_dtime: got n=%0d at %0d want 1 at %0d",
               done_cnt, done_cyc, last_mv + 1);
    end
    checks++;
    if (err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL cont_err: got %b want 0", err_timeout);
    end
    checks++;
    if (en_cnt != FL + LAT || en_mis != 0) begin
      errors++;
      $display("FAIL cont_en: got %0d mis=%0d want %0d 0",
               en_cnt, en_mis, FL + LAT);
    end
  endtask

  task automatic test_bubbles();
    bit ok;
    run_frame(1, 0, 0, ok);
    checks++;
    if (!ok || acc_q.size() != FL ||
        res_q.size() != FL) begin
      errors++;
      $display("FAIL bub_count: got ok=%b acc=%0d res=%0d want 1 %0d %0d",
               ok, acc_q.size(), res_q.size(), FL, FL);
    end
    for (int i = 0; i < int'(res_q.size()); i++) begin
      checks++;
      if (res_q[i] !== pat(i + 1)) begin
        errors++;
        $display("FAIL bub_res%0d: got %h want %h",
                 i, res_q[i], pat(i + 1));
      end
    end
    checks++;
    if (en_mis != 0 || en_cnt != FL + LAT) begin
      errors++;
      $display("FAIL bub_en: got %0d mis=%0d want %0d 0",
               en_cnt, en_mis, FL + LAT);
    end
    checks++;
    if (mlast_cnt != 1 || mlast_bad != 0 ||
        done_cyc != last_mv + 1) begin
      errors++;
      $display("FAIL bub_last: got cnt=%0d bad=%0d done=%0d want 1 0 %0d",
               mlast_cnt, mlast_bad, done_cyc, last_mv + 1);
    end
  endtask

  task automatic test_random();
    bit ok;
    for (int f = 0; f < 3; f++) begin
      run_frame(2, 1, 0, ok);
      checks++;
      if (!ok || acc_q.size() != FL ||
          res_q.size() != FL) begin
        errors++;
        $display("FAIL rnd%0d_count: got ok=%b acc=%0d res=%0d want %0d",
                 f, ok, acc_q.size(), res_q.size(), FL);
      end
      for (int i = 0; i < int'(res_q.size()) &&
           i < int'(acc_q.size()); i++) begin
        checks++;
        if (res_q[i] !== acc_q[i]) begin
          errors++;
          $display("FAIL rnd%0d_res%0d: got %h want %h",
                   f, i, res_q[i], acc_q[i]);
        end
      end
      checks++;
      if (mlast_cnt != 1 || mlast_bad != 0 ||
          done_cnt != 1 || done_cyc != last_mv + 1) begin
        errors++;
        $display("FAIL rnd%0d_end: got last=%0d bad=%0d done=%0d want 1 0 1",
                 f, mlast_cnt, mlast_bad, done_cnt);
      end
    end
  endtask

  task automatic test_timeout();
    bit ok;
    tie0 = 1'b1;
    run_frame(0, 0, 0, ok);
    tie0 = 1'b0;
    checks++;
    if (!ok || done_cnt != 1) begin
      errors++;
      $display("FAIL to_done: got %0d want 1", done_cnt);
    end
    checks++;
    if (res_q.size() != 0) begin
      errors++;
      $display("FAIL to_mvalid: got %0d want 0", res_q.size());
    end
    checks++;
    if (err_timeout !== 1'b1) begin
      errors++;
      $display("FAIL to_err: got %b want 1", err_timeout);
    end
    checks++;
    if (drain_cyc != LAT + 4) begin
      errors++;
      $display("FAIL to_drain: got %0d want %0d",
               drain_cyc, LAT + 4);
    end
  endtask

  task automatic test_start_ignored();
    bit ok;
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || err_timeout !== 1'b1) begin
      errors++;
      $display("FAIL ign_abort: got busy=%b err=%b want 0 1",
               busy, err_timeout);
    end
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL ign_latch: got busy=%b want 0", busy);
    end
    run_frame(0, 0, 1, ok);
    checks++;
    if (!ok || done_cnt != 1 || res_q.size() != FL) begin
      errors++;
      $display("FAIL ign_frame: got done=%0d res=%0d want 1 %0d",
               done_cnt, res_q.size(), FL);
    end
    for (int i = 0; i < int'(res_q.size()); i++) begin
      checks++;
      if (res_q[i] !== pat(i + 1)) begin
        errors++;
        $display("FAIL ign_res%0d: got %h want %h",
                 i, res_q[i], pat(i + 1));
      end
    end
    checks++;
    if (err_timeout !== 1'b0 || mlast_cnt != 1) begin
      errors++;
      $display("FAIL ign_flags: got err=%b last=%0d want 0 1",
               err_timeout, mlast_cnt);
    end
  endtask

  task automatic test_abort();
    bit ok;
    int idx = 0;
    int n = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    while (idx < 7 && n < BUDGET) begin
      s_valid = 1'b1;
      set_words(0, idx + 1);
      if (s_ready) idx++;
      step();
      n++;
    end
    s_valid = 1'b0;
    checks++;
    if (idx != 7) begin
      errors++;
      $display("FAIL ab_reach: got %0d want 7", idx);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || cpe_en !== 1'b0) begin
      errors++;
      $display("FAIL ab_stop: got busy=%b en=%b want 0 0",
               busy, cpe_en);
    end
    repeat (LAT + 4) step();
    checks++;
    if (done_cnt != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ab_nodone: got done=%0d busy=%b want 0 0",
               done_cnt, busy);
    end
    run_frame(0, 0, 0, ok);
    checks++;
    if (!ok || res_q.size() != FL || mlast_cnt != 1) begin
      errors++;
      $display("FAIL ab_next: got res=%0d last=%0d want %0d 1",
               res_q.size(), mlast_cnt, FL);
    end
    for (int i = 0; i < int'(res_q.size()); i++) begin
      checks++;
      if (res_q[i] !== pat(i + 1)) begin
        errors++;
        $display("FAIL ab_res%0d: got %h want %h",
                 i, res_q[i], pat(i + 1));
      end
    end
  endtask

  task automatic test_reset_drain();
    bit ok;
    int idx = 0;
    int n = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    while (!(busy && !s_ready) && n < BUDGET) begin
      s_valid = 1'b1;
      set_words(0, idx + 1);
      if (s_ready) idx++;
      step();
      n++;
    end
    s_valid = 1'b0;
    step();
    checks++;
    if (idx != FL || cpe_en !== 1'b1) begin
      errors++;
      $display("FAIL rd_drain: got idx=%0d en=%b want %0d 1",
               idx, cpe_en, FL);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || cpe_en !== 1'b0 ||
        s_ready !== 1'b0) begin
      errors++;
      $display("FAIL rd_async: got busy=%b en=%b rdy=%b want 000",
               busy, cpe_en, s_ready);
    end
    checks++;
    if (m_valid !== 1'b0 || m_last !== 1'b0 ||
        done !== 1'b0 || err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL rd_flags: got %b%b%b%b want 0000",
               m_valid, m_last, done, err_timeout);
    end
    checks++;
    if ({cpe_re_hi, cpe_im_hi, cpe_re_ui,
         cpe_im_ui} !== '0) begin
      errors++;
      $display("FAIL rd_data: got %h want 0", cpe_re_hi);
    end
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_frame(0, 0, 0, ok);
    checks++;
    if (!ok || res_q.size() != FL ||
        mlast_cnt != 1 || done_cnt != 1) begin
      errors++;
      $display("FAIL rd_next: got res=%0d last=%0d done=%0d want %0d 1 1",
               res_q.size(), mlast_cnt, done_cnt, FL);
    end
    for (int i = 0; i < int'(res_q.size()); i++) begin
      checks++;
      if (res_q[i] !== pat(i + 1)) begin
        errors++;
        $display("FAIL rd_res%0d: got %h want %h",
                 i, res_q[i], pat(i + 1));
      end
    end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_bubbles();
    test_random();
    test_timeout();
    test_start_ignored();
    test_abort();
    test_reset_drain();
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

endmodule

// File: doc/cpe_frame_ctrl.md
# cpe_frame_ctrl

Frame sequencer for the common-phase-error (CPE) estimator in the APSK demapper chain. Accepts a handshaked stream of channel/equalised symbol pairs, presents exactly FRAME_LEN samples per frame to the CPE pipeline, and flushes the pipeline with zero samples at frame end. It gates the CPE outputs so downstream logic sees exactly FRAME_LEN results, with a last-of-frame marker. It sits between the symbol buffer and CPE, and is started per frame by the demapper top-level controller.

## Interface

- WL, 18, sample word length (two's complement)
- FRAME_LEN, 16200, symbols per frame (short frame)
- CPE_LAT, 8, cycles from cpe_en-qualified input to the matching cpe_valid
- CNT_W, 14, counter width; must satisfy 2^CNT_W > FRAME_LEN

- clk, in, 1, system clock, rising edge
- rst_n, in, 1, asynchronous active-low reset
- start, in, 1, one-cycle pulse; begins a frame when in IDLE; ignored elsewhere
- abort, in, 1, synchronous abort; overrides everything except reset
- s_valid, in, 1, upstream sample valid
- s_ready, out, 1, controller accepts a sample this cycle
- s_re_h / s_im_h / s_re_u / s_im_u, in, WL each, channel and received sample parts
- cpe_en, out, 1, CPE pipeline enable
- cpe_re_hi / cpe_im_hi / cpe_re_ui / cpe_im_ui, out, WL each, registered CPE inputs
- cpe_valid, in, 1, CPE output valid
- m_valid, out, 1, gated CPE result valid (cpe_valid qualified)
- m_last, out, 1, asserted with m_valid on result number FRAME_LEN
- busy, out, 1, state is not IDLE
- done, out, 1, one-cycle pulse at normal frame completion
- err_timeout, out, 1, sticky; drain exceeded its budget; cleared by start or reset

## Operation

- States: IDLE, RUN, DRAIN, DONE. Reset: IDLE; all outputs 0; counters 0.
- IDLE: s_ready=0, cpe_en=0. start -> RUN; in_cnt, out_cnt, drain_cnt cleared; err_timeout cleared.
- RUN: s_ready = (in_cnt < FRAME_LEN). Accept = s_valid & s_ready. On accept: register the four sample words onto cpe_* ports, cpe_en=1 next cycle, in_cnt++. No accept: cpe_en=0 next cycle, cpe_* hold their values. Accept with in_cnt reaching FRAME_LEN -> DRAIN.
- DRAIN: s_ready=0; cpe_en=1 every cycle with cpe_* inputs forced to 0; drain_cnt++ per cycle. out_cnt == FRAME_LEN -> DONE. drain_cnt reaching CPE_LAT+4 first -> set err_timeout, go DONE.
- DONE: cpe_en=0; done=1 for exactly this one cycle; -> IDLE.
- Output gating (all states): m_valid = cpe_valid & busy & (out_cnt < FRAME_LEN), combinational; out_cnt++ on m_valid; m_last = m_valid & (out_cnt == FRAME_LEN-1). cpe_valid with out_cnt == FRAME_LEN (flush results) is dropped.
- abort in any state: next state IDLE, cpe_en=0, counters cleared, done not pulsed, err_timeout unchanged. abort with start in the same cycle: abort wins, and start is not latched.
- start while busy: ignored, with no error.
- Counters saturate: in_cnt never exceeds FRAME_LEN, and neither does out_cnt.

## Timing

- Accept at edge k -> cpe_en=1 and data valid on cpe_* during cycle k+1 (1-cycle latency).
- s_ready is a function of registered state/in_cnt only; it is never combinationally dependent on s_valid.
- Full frame with no stalls: start at cycle 0; RUN at cycle 1; accepts at cycles 1..FRAME_LEN; DRAIN from FRAME_LEN+1; last m_valid near FRAME_LEN+CPE_LAT; done one cycle after the last m_valid.
- Upstream bubbles (s_valid=0) create cpe_en=0 cycles; CPE holds state, and no result is lost or duplicated.
- Async reset mid-frame: all outputs 0 immediately; state is IDLE after release.

## Test plan

Run with FRAME_LEN=16, CPE_LAT=4, and a behavioural CPE model: an en-gated 4-stage delay line, with valid after fill.

- Continuous s_valid, sample i = i on all words -> 16 accepts, cpe_en high 16+drain cycles, 16 m_valid with values 1..16 in order, m_last on the 16th, done one cycle after it, no err_timeout.
- s_valid toggling 1,0,1,0 -> still exactly 16 accepts, 16 m_valid, order preserved, cpe_en low on bubble cycles.
- CPE model with valid tied 0 -> DRAIN lasts CPE_LAT+4=8 cycles, err_timeout=1, done pulses, m_valid never asserts.
- abort at accept 7 -> busy=0 next cycle, cpe_en=0, no done; the next start runs a clean 16-sample frame.
- rst_n low for 2 cycles during DRAIN -> all outputs 0 asynchronously; start after release works normally.
- start pulsed during RUN, plus start and abort in the same IDLE cycle -> both ignored; frame count and m_valid count are unaffected.
